// File: rtl/mux_select_unit_if.sv
// Bundles the mux_select_unit data inputs, selects, qualifier and results into one port.
// Optional parity outputs are present only when MUX_SELECT_PARITY_EN is defined.
interface mux_select_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] in3;
    logic             sel2;
    logic [1:0]       sel4;
    logic             valid_in;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out4;
    logic [WIDTH-1:0] out2_q;
    logic [WIDTH-1:0] out4_q;
    logic             valid_q;
`ifdef MUX_SELECT_PARITY_EN
    logic             out2_par;
    logic             out4_par;

    modport master (
        output in0, in1, in2, in3, sel2, sel4, valid_in,
        input  out2, out4, out2_q, out4_q, valid_q, out2_par, out4_par
    );
    modport slave (
        input  in0, in1, in2, in3, sel2, sel4, valid_in,
        output out2, out4, out2_q, out4_q, valid_q, out2_par, out4_par
    );
`else
    modport master (
        output in0, in1, in2, in3, sel2, sel4, valid_in,
        input  out2, out4, out2_q, out4_q, valid_q
    );
    modport slave (
        input  in0, in1, in2, in3, sel2, sel4, valid_in,
        output out2, out4, out2_q, out4_q, valid_q
    );
`endif
endinterface

// File: rtl/mux_select_unit.sv
// 2:1 and 4:1 select on a shared bus, combinational plus registered copies (MUX_SELECT_PARITY_EN adds parity).
// Latency: out2/out4 combinational; out2_q/out4_q/valid_q one cycle after valid_in.
// No backpressure: each registered result is valid for exactly the cycle valid_q is high.
module mux_select_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    mux_select_unit_if.slave   bus
);

    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out4;
    logic [WIDTH-1:0] out2_q;
    logic [WIDTH-1:0] out4_q;
    logic             valid_q;

    // Unknown selects fall to the default arm so simulation shows all-X.
    always_comb begin
        out2 = 'x;
        case (bus.sel2)
            1'b0:    out2 = bus.in0;
            1'b1:    out2 = bus.in1;
            default: out2 = 'x;
        endcase
    end

    always_comb begin
        out4 = 'x;
        case (bus.sel4)
            2'b00:   out4 = bus.in0;
            2'b01:   out4 = bus.in1;
            2'b10:   out4 = bus.in2;
            2'b11:   out4 = bus.in3;
            default: out4 = 'x;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out2_q  <= '0;
            out4_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.valid_in;
            if (bus.valid_in) begin
                out2_q <= out2;
                out4_q <= out4;
            end
        end
    end

    assign bus.out2    = out2;
    assign bus.out4    = out4;
    assign bus.out2_q  = out2_q;
    assign bus.out4_q  = out4_q;
    assign bus.valid_q = valid_q;

`ifdef MUX_SELECT_PARITY_EN
    logic out2_par;
    logic out4_par;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out2_par <= 1'b0;
            out4_par <= 1'b0;
        end else if (bus.valid_in) begin
            out2_par <= ^out2;
            out4_par <= ^out4;
        end
    end

    assign bus.out2_par = out2_par;
    assign bus.out4_par = out4_par;
`endif

endmodule

// File: tb/tb_mux_select_unit.sv
// Directed bench for mux_select_unit: combinational checks plus a queue scoreboard for the registered path.
module tb_mux_select_unit;

    logic clk;
    logic reset_n;
    int   errors;
    int   checks;

    typedef struct {
        logic [31:0] o2;
        logic [31:0] o4;
        logic        p2;
        logic        p4;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] hold2;
    logic [31:0] hold4;
    logic        holdp2;
    logic        holdp4;

    mux_select_unit_if #(.WIDTH(32)) bus ();

    mux_select_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] model2(input logic s, input logic [31:0] a, input logic [31:0] b);
        return s ? b : a;
    endfunction

    function automatic logic [31:0] model4(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        r = a;
        if (s == 2'd1) r = b;
        if (s == 2'd2) r = c;
        if (s == 2'd3) r = d;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic rn, input logic v, input logic s2, input logic [1:0] s4,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3);
        reset_n      = rn;
        bus.valid_in = v;
        bus.sel2     = s2;
        bus.sel4     = s4;
        bus.in0      = d0;
        bus.in1      = d1;
        bus.in2      = d2;
        bus.in3      = d3;
        #1;
        chk("out2_comb", bus.out2, model2(s2, d0, d1));
        chk("out4_comb", bus.out4, model4(s4, d0, d1, d2, d3));
    endtask

    task automatic tick();
        exp_t e;
        logic rn;
        logic ev;
        rn = reset_n;
        ev = reset_n && bus.valid_in;
        if (ev) begin
            e.o2 = model2(bus.sel2, bus.in0, bus.in1);
            e.o4 = model4(bus.sel4, bus.in0, bus.in1, bus.in2, bus.in3);
            e.p2 = ^e.o2;
            e.p4 = ^e.o4;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        chk("valid_q", {31'b0, bus.valid_q}, {31'b0, ev});
        if (!rn) begin
            hold2  = '0;
            hold4  = '0;
            holdp2 = 1'b0;
            holdp4 = 1'b0;
            sbq.delete();
        end else if (bus.valid_q && sbq.size() > 0) begin
            e      = sbq.pop_front();
            hold2  = e.o2;
            hold4  = e.o4;
            holdp2 = e.p2;
            holdp4 = e.p4;
        end
        chk("out2_q", bus.out2_q, hold2);
        chk("out4_q", bus.out4_q, hold4);
`ifdef MUX_SELECT_PARITY_EN
        chk("out2_par", {31'b0, bus.out2_par}, {31'b0, holdp2});
        chk("out4_par", {31'b0, bus.out4_par}, {31'b0, holdp4});
`endif
    endtask

    initial begin
        errors = 0;
        checks = 0;
        hold2  = '0;
        hold4  = '0;
        holdp2 = 1'b0;
        holdp4 = 1'b0;

        // Reset state
        apply(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        tick();

        // 2:1 combinational
        apply(1'b1, 1'b0, 1'b0, 2'd0, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'h2, 32'h3);
        chk("tp_out2_sel0", bus.out2, 32'hAAAAAAAA);
        apply(1'b1, 1'b0, 1'b1, 2'd0, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'h2, 32'h3);
        chk("tp_out2_sel1", bus.out2, 32'hBBBBBBBB);

        // 4:1 combinational, select stepped through every code
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b0, 1'b0, 2'(i), 32'h0, 32'h1, 32'h2, 32'h3);
            chk("tp_out4_step", bus.out4, 32'(i));
        end
        tick();

        // Registered capture
        apply(1'b1, 1'b1, 1'b1, 2'b10, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'h2, 32'h3);
        tick();
        chk("tp_cap_out2_q", bus.out2_q, 32'hBBBBBBBB);
        chk("tp_cap_out4_q", bus.out4_q, 32'h2);

        // Hold with changed inputs
        apply(1'b1, 1'b0, 1'b0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        tick();
        chk("tp_hold_out2_q", bus.out2_q, 32'hBBBBBBBB);
        chk("tp_hold_out4_q", bus.out4_q, 32'h2);

        // Back-to-back and sparse traffic
        for (int i = 0; i < 24; i++) begin
            apply(1'b1, (i < 8) ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), $urandom(), $urandom(), $urandom(), $urandom());
            tick();
        end

        // Reset wins over valid_in; combinational path keeps tracking
        apply(1'b1, 1'b1, 1'b0, 2'b11, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hDEADBEEF);
        tick();
        apply(1'b0, 1'b1, 1'b1, 2'b11, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        tick();
        chk("tp_rst_out2_q", bus.out2_q, 32'h0);
        chk("tp_rst_out4_q", bus.out4_q, 32'h0);
        chk("tp_rst_out2_comb", bus.out2, 32'h22222222);
        chk("tp_rst_out4_comb", bus.out4, 32'h44444444);

        // Parity-relevant captures
        apply(1'b1, 1'b1, 1'b0, 2'b11, 32'h0, 32'h1, 32'h2, 32'h3);
        tick();
        chk("tp_par_cap3", bus.out4_q, 32'h00000003);
`ifdef MUX_SELECT_PARITY_EN
        chk("tp_par_out4_0", {31'b0, bus.out4_par}, 32'h0);
`endif
        apply(1'b1, 1'b1, 1'b0, 2'b01, 32'h0, 32'h1, 32'h2, 32'h3);
        tick();
        chk("tp_par_cap1", bus.out4_q, 32'h00000001);
`ifdef MUX_SELECT_PARITY_EN
        chk("tp_par_out4_1", {31'b0, bus.out4_par}, 32'h1);
`endif
        apply(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_select_unit.md
Name: mux_select_unit

Overview:
- Parameterised data-select block providing a 2:1 and a 4:1 multiplexer path on a shared input bus.
- Each path has a combinational output and a registered output with a valid flag.
- Sits in the datapath wherever operand or result selection is needed; the registered outputs let downstream logic break timing.

Parameters:
- WIDTH, 32, bit width of every data input and output.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- in0  input  WIDTH  data input 0; feeds both paths.
- in1  input  WIDTH  data input 1; feeds both paths.
- in2  input  WIDTH  data input 2; feeds the 4:1 path only.
- in3  input  WIDTH  data input 3; feeds the 4:1 path only.
- sel2  input  1  2:1 select.
- sel4  input  2  4:1 select.
- valid_in  input  1  input sample qualifier for the registered outputs.
- out2  output  WIDTH  combinational 2:1 result.
- out4  output  WIDTH  combinational 4:1 result.
- out2_q  output  WIDTH  registered 2:1 result.
- out4_q  output  WIDTH  registered 4:1 result.
- valid_q  output  1  registered outputs hold a newly captured sample.

Behaviour:
- Combinational path, pure logic, no clock dependence:
  - out2 = in0 when sel2=0, in1 when sel2=1.
  - out4 = in0/in1/in2/in3 for sel4 = 00/01/10/11.
- Any X or Z on a select drives the corresponding output to all-X in simulation; synthesis may resolve it freely.
- Registered path, updated on the rising clk edge:
  - reset_n=0 at the edge: out2_q=0, out4_q=0, valid_q=0. Reset has priority over valid_in.
  - reset_n=1, valid_in=1: out2_q<=out2, out4_q<=out4, valid_q<=1.
  - reset_n=1, valid_in=0: out2_q and out4_q hold their previous values; valid_q<=0.
- Latency: registered outputs follow the inputs by exactly 1 cycle. Back-to-back valid_in gives one result per cycle with no bubbles.
- No backpressure. Downstream logic must consume each result in the cycle valid_q=1.
- Reset asserted mid-stream: the in-flight sample is discarded and outputs clear at the next edge. Combinational outputs are unaffected by reset.
- Widths: no arithmetic, no truncation. All data buses are exactly WIDTH bits.

Optional Feature:
- Macro MUX_SELECT_PARITY_EN.
- When defined, adds two outputs:
  - out2_par, output, 1 bit.
  - out4_par, output, 1 bit.
- Each is the even parity (XOR reduction) of the value captured into out2_q or out4_q, registered alongside it.
- Each follows the same reset, capture and hold rules as its data register; it resets to 0.
- When undefined, these ports and their registers do not exist. All other behaviour is identical.

Test Plan:
- 2:1 combinational: in0=AAAAAAAA, in1=BBBBBBBB, sel2=0 -> out2=AAAAAAAA; sel2=1 -> out2=BBBBBBBB.
- 4:1 combinational: in0..in3=0,1,2,3, sel4 stepped 00,01,10,11 -> out4=0,1,2,3.
- Registered capture: reset_n=1, valid_in=1, sel2=1, sel4=10 with the above data -> next cycle out2_q=BBBBBBBB, out4_q=2, valid_q=1.
- Hold: valid_in=0, inputs changed to in0..in3=FFFFFFFF -> out2_q and out4_q unchanged, valid_q=0.
- Reset: reset_n=0 together with valid_in=1 -> next edge out2_q=0, out4_q=0, valid_q=0; out2/out4 still track inputs combinationally.
- With MUX_SELECT_PARITY_EN: capture out4_q=00000003 -> out4_par=0; capture out4_q=00000001 -> out4_par=1.
